// File: rtl/sprite_line_scanner.sv
// rtl/sprite_line_scanner.sv - per-scanline sprite scanner feeding the sprite drawer
// Optional vertical flip of row_off is enabled by defining SPRITE_VFLIP_EN.
module sprite_line_scanner #(
    parameter int NUM_SPRITE    = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int SPRITE_H      = 16,
    parameter int MAX_PER_LINE  = 16,
    parameter int VISIBLE_LINES = 480,
    parameter int RD_LAT        = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start_row,
    input  logic [9:0]                        next_vcount,
    output logic [$clog2(NUM_SPRITE)-1:0]     ra,
    input  logic [31:0]                       rd_data,
    output logic                              draw_valid,
    input  logic                              draw_ready,
    output logic [9:0]                        col_base,
    output logic                              hflip,
    output logic [7:0]                        frame_id,
    output logic [$clog2(SPRITE_H)-1:0]       row_off,
    output logic [$clog2(MAX_PER_LINE+1)-1:0] hit_count,
    output logic                              line_overflow,
    output logic                              fe_done
);
    localparam int AW = $clog2(NUM_SPRITE);
    localparam int RW = $clog2(SPRITE_H);
    localparam int CW = $clog2(MAX_PER_LINE + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam int EW = 10 + 1 + 8 + RW;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t            state;
    logic [9:0]        line_v;
    logic [RD_LAT-1:0] pipe_v;
    logic [EW-1:0]     q_mem [FIFO_DEPTH];
    logic [PW-1:0]     q_wr;
    logic [PW-1:0]     q_rd;
    logic [OW-1:0]     q_cnt;

    logic          rd_vld;
    logic          hit;
    logic          accept;
    logic          drop;
    logic          load;
    logic          from_q;
    logic          bypass;
    logic          push;
    logic          issue;
    logic [OW:0]   in_flight;
    logic [9:0]    diff;
    logic [RW-1:0] row;
    logic [EW-1:0] hit_entry;
    logic          unused_bits;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + (OW+1)'(pipe_v[i]);
        end
        rd_vld = pipe_v[RD_LAT-1];
        hit = rd_vld && rd_data[31]
              && ({1'b0, line_v} >= {2'b00, rd_data[26:18]})
              && ({1'b0, line_v} < ({2'b00, rd_data[26:18]} + 11'(SPRITE_H)));
        diff = line_v - {1'b0, rd_data[26:18]};
        row  = diff[RW-1:0];
`ifdef SPRITE_VFLIP_EN
        if (rd_data[29]) begin
            row = ~diff[RW-1:0];
        end
`endif
        hit_entry = {rd_data[17:8], rd_data[30], rd_data[7:0], row};
        accept = hit && (hit_count != CW'(MAX_PER_LINE));
        drop   = hit && (hit_count == CW'(MAX_PER_LINE));
        load   = !draw_valid || draw_ready;
        from_q = load && (q_cnt != '0);
        // An empty queue lets a fresh hit go straight to the output register.
        bypass = load && (q_cnt == '0) && accept;
        push   = accept && !bypass;
        issue  = (state == SCAN) && !drop
                 && (({1'b0, q_cnt} + in_flight) < (OW+1)'(FIFO_DEPTH));
    end

`ifdef SPRITE_VFLIP_EN
    assign unused_bits = ^{rd_data[28:27], diff[9:RW]};
`else
    assign unused_bits = ^{rd_data[29:27], diff[9:RW]};
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[q_wr] <= hit_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            line_v        <= '0;
            ra            <= '0;
            pipe_v        <= '0;
            q_wr          <= '0;
            q_rd          <= '0;
            q_cnt         <= '0;
            draw_valid    <= 1'b0;
            col_base      <= '0;
            hflip         <= 1'b0;
            frame_id      <= '0;
            row_off       <= '0;
            hit_count     <= '0;
            line_overflow <= 1'b0;
            fe_done       <= 1'b1;
        end else if (start_row) begin
            line_v        <= next_vcount;
            ra            <= '0;
            pipe_v        <= '0;
            q_wr          <= '0;
            q_rd          <= '0;
            q_cnt         <= '0;
            draw_valid    <= 1'b0;
            hit_count     <= '0;
            line_overflow <= 1'b0;
            if ({1'b0, next_vcount} < 11'(VISIBLE_LINES)) begin
                state   <= SCAN;
                fe_done <= 1'b0;
            end else begin
                state   <= IDLE;
                fe_done <= 1'b1;
            end
        end else begin
            pipe_v[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
            if (issue && (ra != AW'(NUM_SPRITE - 1))) begin
                ra <= ra + AW'(1);
            end
            if (accept) begin
                hit_count <= hit_count + CW'(1);
            end
            if (drop) begin
                line_overflow <= 1'b1;
            end
            if (push) begin
                q_wr <= q_wr + PW'(1);
            end
            if (from_q) begin
                q_rd <= q_rd + PW'(1);
            end
            case ({push, from_q})
                2'b10:   q_cnt <= q_cnt + OW'(1);
                2'b01:   q_cnt <= q_cnt - OW'(1);
                default: q_cnt <= q_cnt;
            endcase
            if (from_q) begin
                {col_base, hflip, frame_id, row_off} <= q_mem[q_rd];
                draw_valid <= 1'b1;
            end else if (bypass) begin
                {col_base, hflip, frame_id, row_off} <= hit_entry;
                draw_valid <= 1'b1;
            end else if (load) begin
                draw_valid <= 1'b0;
            end
            case (state)
                SCAN: begin
                    if (drop || (issue && (ra == AW'(NUM_SPRITE - 1)))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((in_flight == '0) && (q_cnt == '0) && !draw_valid && draw_ready) begin
                        state   <= IDLE;
                        fe_done <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    a_no_overfill: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (q_cnt == OW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sprite_line_scanner.sv
// tb/tb_sprite_line_scanner.sv - randomized self-checking bench for sprite_line_scanner
module tb_sprite_line_scanner;
    localparam int NS   = 32;
    localparam int MAXL = 16;
    localparam int SH   = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_row;
    logic [9:0]  next_vcount;
    logic [4:0]  ra;
    logic [31:0] rd_data;
    logic        draw_valid;
    logic        draw_ready;
    logic [9:0]  col_base;
    logic        hflip;
    logic [7:0]  frame_id;
    logic [3:0]  row_off;
    logic [4:0]  hit_count;
    logic        line_overflow;
    logic        fe_done;

    logic [31:0] tbl [NS];
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    int          exp_hits;
    int          first_valid_k;
    int          done_k;
    int          n_checks = 0;
    int          n_pass = 0;

    sprite_line_scanner dut (
        .clk(clk), .reset_n(reset_n), .start_row(start_row), .next_vcount(next_vcount),
        .ra(ra), .rd_data(rd_data), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .col_base(col_base), .hflip(hflip), .frame_id(frame_id), .row_off(row_off),
        .hit_count(hit_count), .line_overflow(line_overflow), .fe_done(fe_done)
    );

    always #5 clk = ~clk;

    // Attribute table: synchronous read, one cycle latency.
    always @(posedge clk) rd_data <= tbl[ra];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk(input bit en, input bit hf, input bit vf,
                                       input int y, input int x, input int fr);
        return {en, hf, vf, 2'b00, 9'(y), 10'(x), 8'(fr)};
    endfunction

    task automatic clear_table();
        for (int i = 0; i < NS; i++) tbl[i] = 32'd0;
    endtask

    task automatic build_expect(input int v);
        exp_q.delete();
        exp_hits = 0;
        for (int i = 0; i < NS; i++) begin
            logic [31:0] w;
            int y;
            int d;
            int r;
            w = tbl[i];
            y = int'(w[26:18]);
            d = v - y;
            if (v < 480 && w[31] && d >= 0 && d < SH) begin
                exp_hits++;
                if (exp_hits <= MAXL) begin
                    r = d;
`ifdef SPRITE_VFLIP_EN
                    if (w[29]) r = SH - 1 - d;
`endif
                    exp_q.push_back({9'd0, w[17:8], w[30], w[7:0], 4'(r)});
                end
            end
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ra"}, 32'(ra), 0);
        check({pfx, "_dv"}, 32'(draw_valid), 0);
        check({pfx, "_col"}, 32'(col_base), 0);
        check({pfx, "_hflip"}, 32'(hflip), 0);
        check({pfx, "_frame"}, 32'(frame_id), 0);
        check({pfx, "_row"}, 32'(row_off), 0);
        check({pfx, "_hits"}, 32'(hit_count), 0);
        check({pfx, "_ovf"}, 32'(line_overflow), 0);
        check({pfx, "_done"}, 32'(fe_done), 1);
    endtask

    // mode 0: ready held high, 1: toggling, 2: random
    task automatic run_line(input int v, input int mode);
        int k;
        bit done;
        int n;
        build_expect(v);
        got_q.delete();
        first_valid_k = -1;
        done_k = -1;
        @(negedge clk);
        start_row = 1'b1;
        next_vcount = 10'(v);
        draw_ready = 1'b0;
        @(negedge clk);
        start_row = 1'b0;
        check($sformatf("dv_after_start_v%0d", v), 32'(draw_valid), 0);
        k = 1;
        done = 1'b0;
        while (!done && k < 3000) begin
            if (draw_valid && first_valid_k < 0) first_valid_k = k;
            if (fe_done) begin
                done_k = k;
                done = 1'b1;
            end else begin
                case (mode)
                    0:       draw_ready = 1'b1;
                    1:       draw_ready = (k % 2 == 1);
                    default: draw_ready = ($urandom % 3) != 0;
                endcase
                if (draw_valid && draw_ready)
                    got_q.push_back({9'd0, col_base, hflip, frame_id, row_off});
                @(negedge clk);
                k++;
            end
        end
        if (!done) check($sformatf("timeout_v%0d", v), 0, 1);
        check($sformatf("n_desc_v%0d", v), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("desc%0d_v%0d", i, v), got_q[i], exp_q[i]);
        check($sformatf("hit_count_v%0d", v), 32'(hit_count),
              (exp_hits > MAXL) ? MAXL : exp_hits);
        check($sformatf("overflow_v%0d", v), 32'(line_overflow), 32'(exp_hits > MAXL));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        reset_n = 1'b0;
        start_row = 1'b0;
        next_vcount = '0;
        draw_ready = 1'b0;
        clear_table();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;

        clear_table();
        tbl[5] = mk(1, 0, 0, 100, 200, 7);
        run_line(103, 0);
        check("single_row_off", (got_q.size() > 0) ? 32'(got_q[0][3:0]) : 32'hdead, 3);

        clear_table();
        tbl[0] = mk(1, 1, 0, 50, 123, 4);
        run_line(50, 0);
        check("first_valid_latency", first_valid_k, 3);

        clear_table();
        run_line(300, 0);
        check("zero_hit_done", done_k, 35);

        for (int i = 0; i < NS; i++) tbl[i] = mk(1, i % 2, 0, 5, i * 3, i);
        run_line(10, 1);

        clear_table();
        tbl[9] = mk(1, 0, 0, 470, 640, 33);
        run_line(469, 2);
        run_line(470, 2);
        run_line(479, 2);
        run_line(480, 0);
        check("invisible_done", done_k, 1);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (!fe_done || ra != 5'd0 || draw_valid) bad++;
        end
        check("invisible_idle", bad, 0);

        clear_table();
        tbl[2] = mk(1, 0, 1, 0, 77, 12);
        run_line(2, 0);
`ifdef SPRITE_VFLIP_EN
        check("vflip_row", (got_q.size() > 0) ? 32'(got_q[0][3:0]) : 32'hdead, 13);
`else
        check("vflip_row", (got_q.size() > 0) ? 32'(got_q[0][3:0]) : 32'hdead, 2);
`endif

        clear_table();
        for (int i = 0; i < 10; i++) tbl[i] = mk(1, 0, 0, 20, i * 10, i);
        for (int i = 10; i < 15; i++) tbl[i] = mk(1, 1, 0, 200, i * 20, i + 100);
        @(negedge clk);
        start_row = 1'b1;
        next_vcount = 10'd25;
        draw_ready = 1'b0;
        @(negedge clk);
        start_row = 1'b0;
        repeat (12) @(negedge clk);
        check("queued_valid", 32'(draw_valid), 1);
        run_line(205, 0);

        clear_table();
        tbl[3]  = mk(1, 1, 0, 60, 300, 9);
        tbl[7]  = mk(1, 0, 0, 58, 301, 10);
        tbl[20] = mk(1, 0, 0, 55, 302, 11);
        @(negedge clk);
        start_row = 1'b1;
        next_vcount = 10'd61;
        draw_ready = 1'b0;
        @(negedge clk);
        start_row = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_drain_busy", 32'(fe_done), 0);
        check("mid_drain_valid", 32'(draw_valid), 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NS; i++)
                tbl[i] = mk(($urandom % 4) != 0, $urandom % 2, $urandom % 2,
                            $urandom_range(0, 70), $urandom_range(0, 1023), $urandom_range(0, 255));
            run_line($urandom_range(0, 90), $urandom % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
